// File: rtl/mips_sim_pkg.sv
// Shared definitions for the MIPS simulation/run-control slice:
// run_state encoding, default signature constants and bus widths.
package mips_sim_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRstHold = 2'd1,
        StRun     = 2'd2,
        StDone    = 2'd3
    } run_state_e;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned CntWidth  = 32;

    localparam logic [31:0] DefaultSigAddr = 32'h0000_0C00;
    localparam logic [31:0] DefaultPassVal = 32'h0000_0001;

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Core-facing bundle: reset out to the core, retire and store activity back from it.
interface mips_run_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              core_rst_n;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // master: the run controller; slave: the core being sequenced
    modport master (
        output core_rst_n,
        input  pc, pc_valid, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  core_rst_n,
        output pc, pc_valid, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_halt_detect.sv
// Self-loop detector: counts consecutive identical retired PCs and flags the
// retirement that completes HALT_REPEAT of them.
module mips_halt_detect #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned HALT_REPEAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc,
    output logic              halt_hit
);
    localparam int unsigned RepW = $clog2(HALT_REPEAT + 1);
    localparam logic [RepW-1:0] RepMax  = RepW'(HALT_REPEAT);
    localparam logic [RepW-1:0] RepLast = RepW'(HALT_REPEAT - 1);

    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic [RepW-1:0]   rep_q, rep_d;
    logic              same_pc;

    always_comb begin
        last_pc_d = last_pc_q;
        rep_d     = rep_q;
        same_pc   = (pc == last_pc_q);
        // Completing the run of identical PCs is judged on the incoming retirement
        halt_hit  = en && pc_valid && same_pc && (rep_q >= RepLast);
        if (clear) begin
            last_pc_d = '0;
            rep_d     = '0;
        end else if (en && pc_valid) begin
            last_pc_d = pc;
            if (!same_pc)            rep_d = RepW'(1);
            else if (rep_q != RepMax) rep_d = rep_q + RepW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc_q <= '0;
            rep_q     <= '0;
        end else begin
            last_pc_q <= last_pc_d;
            rep_q     <= rep_d;
        end
    end
endmodule

// File: rtl/mips_run_ctrl.sv
// Run sequencer: holds the core in reset, then counts cycles/retirements until a
// signature store, self-loop halt or timeout ends the run.
module mips_run_ctrl
    import mips_sim_pkg::*;
#(
    parameter int unsigned       ADDR_W       = AddrWidth,
    parameter int unsigned       DATA_W       = DataWidth,
    parameter int unsigned       CNT_W        = CntWidth,
    parameter int unsigned       RESET_CYCLES = 4,
    parameter int unsigned       MAX_CYCLES   = 10000,
    parameter int unsigned       HALT_REPEAT  = 8,
    parameter logic [ADDR_W-1:0] SIG_ADDR     = ADDR_W'(DefaultSigAddr),
    parameter logic [DATA_W-1:0] PASS_VAL     = DATA_W'(DefaultPassVal)
) (
    input  logic             mips_cpu_clk,
    input  logic             mips_cpu_reset,
    input  logic             start,
    mips_run_ctrl_if.master  core,
    output logic [1:0]       run_state,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             halt,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);
    localparam int unsigned HoldW = $clog2(RESET_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CycLast  = CNT_W'(MAX_CYCLES - 1);

    run_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, retire_q, retire_d;
    logic             done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic             halt_q, halt_d, timeout_q, timeout_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             clear_run, run_en, halt_hit, sig_hit;

    assign run_en  = (state_q == StRun);
    assign sig_hit = core.mem_wen && (core.mem_addr == SIG_ADDR);

    mips_halt_detect #(
        .ADDR_W      (ADDR_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_detect (
        .clk      (mips_cpu_clk),
        .rst_n    (mips_cpu_reset),
        .clear    (clear_run),
        .en       (run_en),
        .pc_valid (core.pc_valid),
        .pc       (core.pc),
        .halt_hit (halt_hit)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        halt_d    = halt_q;
        timeout_d = timeout_q;
        clear_run = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StRstHold;
                    clear_run = 1'b1;
                    hold_d    = '0;
                    cycle_d   = '0;
                    retire_d  = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    halt_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            StRstHold: begin
                hold_d = hold_q + HoldW'(1);
                if (hold_q == HoldLast) state_d = StRun;
            end
            StRun: begin
                if (!(&cycle_q)) cycle_d = cycle_q + CNT_W'(1);
                if (core.pc_valid && !(&retire_q)) retire_d = retire_q + CNT_W'(1);
                // Fixed priority: signature, then halt, then timeout
                if (sig_hit) begin
                    pass_d = (core.mem_wdata == PASS_VAL);
                    fail_d = (core.mem_wdata != PASS_VAL);
                end else if (halt_hit) begin
                    halt_d = 1'b1;
                end else if (cycle_q == CycLast) begin
                    timeout_d = 1'b1;
                end
                if (sig_hit || halt_hit || (cycle_q == CycLast)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
        endcase
        core_rst_n_d = (state_d == StRun);
    end

    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset) begin
        if (!mips_cpu_reset) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            cycle_q      <= '0;
            retire_q     <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            halt_q       <= 1'b0;
            timeout_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cycle_q      <= cycle_d;
            retire_q     <= retire_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            halt_q       <= halt_d;
            timeout_q    <= timeout_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign core.core_rst_n = core_rst_n_q;
    assign run_state       = state_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign fail            = fail_q;
    assign halt            = halt_q;
    assign timeout         = timeout_q;
    assign cycle_count     = cycle_q;
    assign retire_count    = retire_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl; the bench plays the core through the interface.
module tb_mips_run_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  run_state;
    logic        done, pass, fail, halt, timeout;
    logic [31:0] cycle_count, retire_count;
    logic [4:0]  flags;
    int          checks = 0;
    int          errors = 0;

    mips_run_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mips_run_ctrl #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .CNT_W        (32),
        .RESET_CYCLES (4),
        .MAX_CYCLES   (100),
        .HALT_REPEAT  (8),
        .SIG_ADDR     (32'h0000_0C00),
        .PASS_VAL     (32'h0000_0001)
    ) dut (
        .mips_cpu_clk   (clk),
        .mips_cpu_reset (rst_n),
        .start          (start),
        .core           (bus),
        .run_state      (run_state),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .halt           (halt),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .retire_count   (retire_count)
    );

    always #5 clk = ~clk;
    assign flags = {done, pass, fail, halt, timeout};

    initial begin
        #2ms;
        $display("FAIL watchdog: sim time expired, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.pc = '0; bus.pc_valid = 1'b0; bus.mem_wen = 1'b0;
        bus.mem_addr = '0; bus.mem_wdata = '0;
    endtask

    // Pulse start and wait out the 4-cycle hold; returns on run cycle 0
    task automatic start_run();
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        idle_bus();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (run_state !== 2'd0) begin errors++;
            $display("FAIL reset_state: got %0d want 0", run_state); end
        checks++; if (bus.core_rst_n !== 1'b0) begin errors++;
            $display("FAIL reset_core_rst_n: got %b want 0", bus.core_rst_n); end
        checks++; if ({flags, cycle_count, retire_count} !== '0) begin errors++;
            $display("FAIL reset_flags_counts: got %b/%0d/%0d want 0/0/0",
                     flags, cycle_count, retire_count); end
    endtask

    task automatic test_hold();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({run_state, bus.core_rst_n} !== {2'd1, 1'b0}) begin errors++;
                $display("FAIL hold_cycle%0d: got state %0d rst_n %b want 1 0",
                         i, run_state, bus.core_rst_n); end
            tick();
        end
        checks++; if ({run_state, bus.core_rst_n} !== {2'd2, 1'b1}) begin errors++;
            $display("FAIL hold_enter_run: got state %0d rst_n %b want 2 1",
                     run_state, bus.core_rst_n); end
        checks++; if (cycle_count !== 32'd0) begin errors++;
            $display("FAIL hold_first_cycle_count: got %0d want 0", cycle_count); end
        // Finish this run with a passing signature so later tests start from DONE
        bus.mem_wen = 1'b1; bus.mem_addr = 32'hC00; bus.mem_wdata = 32'd1;
        tick(); idle_bus();
    endtask

    task automatic test_signature(input logic [31:0] wdata, input logic [4:0] want);
        start_run();
        bus.pc_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bus.pc = 32'(4 * i); tick();
        end
        bus.pc = 32'd200; bus.mem_wen = 1'b1; bus.mem_addr = 32'hC00; bus.mem_wdata = wdata;
        tick(); idle_bus();
        checks++; if (flags !== want) begin errors++;
            $display("FAIL sig_%0h_flags: got %b want %b", wdata, flags, want); end
        checks++; if ({cycle_count, retire_count} !== {32'd51, 32'd51}) begin errors++;
            $display("FAIL sig_%0h_counts: got %0d/%0d want 51/51",
                     wdata, cycle_count, retire_count); end
        checks++; if ({run_state, bus.core_rst_n} !== {2'd3, 1'b0}) begin errors++;
            $display("FAIL sig_%0h_done_state: got %0d %b want 3 0",
                     wdata, run_state, bus.core_rst_n); end
    endtask

    task automatic test_halt();
        start_run();
        bus.pc_valid = 1'b1;
        bus.pc = 32'h0; tick(); bus.pc = 32'h4; tick(); bus.pc = 32'h8; tick();
        repeat (3) tick();
        bus.pc_valid = 1'b0; tick();
        bus.pc_valid = 1'b1;
        repeat (3) tick();
        checks++; if ({flags, run_state} !== {5'b00000, 2'd2}) begin errors++;
            $display("FAIL halt_seventh_repeat: got %b state %0d want 00000 2",
                     flags, run_state); end
        tick(); idle_bus();
        checks++; if (flags !== 5'b10010) begin errors++;
            $display("FAIL halt_eighth_repeat: got %b want 10010", flags); end
        checks++; if ({cycle_count, retire_count} !== {32'd11, 32'd10}) begin errors++;
            $display("FAIL halt_counts: got %0d/%0d want 11/10", cycle_count, retire_count); end
    endtask

    task automatic test_timeout();
        start_run();
        bus.pc_valid = 1'b1;
        for (int i = 0; i < 99; i++) begin
            bus.pc = 32'(4 * i); tick();
        end
        checks++; if ({flags, run_state} !== {5'b00000, 2'd2}) begin errors++;
            $display("FAIL timeout_early: got %b state %0d want 00000 2", flags, run_state); end
        bus.pc = 32'd396; tick(); idle_bus();
        checks++; if (flags !== 5'b10001) begin errors++;
            $display("FAIL timeout_flags: got %b want 10001", flags); end
        checks++; if ({cycle_count, retire_count} !== {32'd100, 32'd100}) begin errors++;
            $display("FAIL timeout_counts: got %0d/%0d want 100/100",
                     cycle_count, retire_count); end
    endtask

    task automatic test_simultaneous();
        start_run();
        bus.pc_valid = 1'b1; bus.pc = 32'h10;
        repeat (7) tick();
        bus.mem_wen = 1'b1; bus.mem_addr = 32'hC00; bus.mem_wdata = 32'd1;
        tick(); idle_bus();
        checks++; if (flags !== 5'b11000) begin errors++;
            $display("FAIL simul_priority: got %b want 11000", flags); end
        checks++; if (cycle_count !== 32'd8) begin errors++;
            $display("FAIL simul_cycle_count: got %0d want 8", cycle_count); end
    endtask

    task automatic test_back_to_back();
        start_run();
        bus.pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pc = 32'(32'h100 + 4 * i); tick();
        end
        bus.pc = 32'h10c; start = 1'b1; tick(); start = 1'b0;
        checks++; if ({run_state, cycle_count} !== {2'd2, 32'd4}) begin errors++;
            $display("FAIL start_in_run_ignored: got state %0d cycle %0d want 2 4",
                     run_state, cycle_count); end
        bus.pc = 32'h110; bus.mem_wen = 1'b1; bus.mem_addr = 32'hC00; bus.mem_wdata = 32'h5;
        tick(); idle_bus();
        checks++; if ({flags, cycle_count} !== {5'b10100, 32'd5}) begin errors++;
            $display("FAIL restart_first_end: got %b cycle %0d want 10100 5",
                     flags, cycle_count); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if ({run_state, flags, cycle_count, retire_count} !== {2'd1, 5'b0, 64'd0})
        begin errors++;
            $display("FAIL restart_clear: got state %0d %b %0d/%0d want 1 00000 0/0",
                     run_state, flags, cycle_count, retire_count); end
        repeat (3) tick();
        bus.pc_valid = 1'b1; bus.pc = 32'h40; tick(); bus.pc = 32'h44; tick(); idle_bus();
        checks++; if ({run_state, cycle_count, retire_count} !== {2'd2, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL restart_second_run: got state %0d %0d/%0d want 2 1/1",
                     run_state, cycle_count, retire_count); end
        bus.mem_wen = 1'b1; bus.mem_addr = 32'hC00; bus.mem_wdata = 32'd1;
        tick(); idle_bus();
    endtask

    task automatic test_async_reset();
        start_run();
        bus.pc_valid = 1'b1;
        bus.pc = 32'h20; tick(); bus.pc = 32'h24; tick();
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({run_state, bus.core_rst_n} !== {2'd0, 1'b0}) begin errors++;
            $display("FAIL async_reset_state: got %0d %b want 0 0", run_state, bus.core_rst_n);
        end
        checks++; if ({flags, cycle_count, retire_count} !== '0) begin errors++;
            $display("FAIL async_reset_clear: got %b %0d/%0d want 00000 0/0",
                     flags, cycle_count, retire_count); end
        idle_bus();
        tick(); rst_n = 1'b1; tick();
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_hold();
        test_signature(32'h0000_0001, 5'b11000);
        test_signature(32'h0000_DEAD, 5'b10100);
        test_halt();
        test_timeout();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Synthesizable run controller for the single-cycle MIPS core and its successors. It replaces fixed-delay reset and stop-after-N-time bench logic with a parametrised sequencer. The sequencer holds the core in reset for a programmable number of cycles, then counts cycles and retired instructions. It ends the run on one of three events: a signature store (pass/fail), a self-loop halt, or a timeout. It sits between the clock/reset source and the core top, and its status outputs feed bench checks or board LEDs.

Parameters:
ADDR_W, 32, width of PC and data-memory address
DATA_W, 32, width of store data
CNT_W, 32, width of cycle and retire counters
RESET_CYCLES, 4, cycles the core reset is held after start (must be >=1)
MAX_CYCLES, 10000, run-phase cycle budget before timeout (must be >=1)
HALT_REPEAT, 8, consecutive identical retired PCs that declare a halt (must be >=2)
SIG_ADDR, 32'h0000_0C00, address of the signature store
PASS_VAL, 32'h0000_0001, signature value meaning pass

Ports:
mips_cpu_clk  in  1  single clock for the whole block
mips_cpu_reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin or restart a run
core_rst_n  out  1  active-low reset driven to the core
pc  in  ADDR_W  PC of the retiring instruction
pc_valid  in  1  an instruction retires this cycle
mem_wen  in  1  data-memory write strobe from the core
mem_addr  in  ADDR_W  data-memory write address
mem_wdata  in  DATA_W  data-memory write data
run_state  out  2  0 IDLE, 1 RST_HOLD, 2 RUN, 3 DONE
done  out  1  run finished (any cause)
pass  out  1  signature equalled PASS_VAL
fail  out  1  signature written with any other value
halt  out  1  self-loop detected
timeout  out  1  MAX_CYCLES exhausted
cycle_count  out  CNT_W  run-phase cycles elapsed
retire_count  out  CNT_W  instructions retired in the run phase

Behaviour:
- Async reset (mips_cpu_reset=0): state IDLE, core_rst_n=0, all flags 0, counters 0, repeat counter 0, last_pc 0. This applies at any time, including mid-run.
- All other state changes happen on the rising edge of mips_cpu_clk. All outputs are registered.
- IDLE: core_rst_n=0. When start=1, go to RST_HOLD. On that same edge, clear done, pass, fail, halt, timeout, both counters, the repeat counter and the hold counter.
- RST_HOLD: core_rst_n=0. The hold counter increments each cycle. After exactly RESET_CYCLES cycles in RST_HOLD, go to RUN. core_rst_n is 1 from the first RUN cycle.
- RUN: core_rst_n=1.
  - cycle_count increments every cycle, saturating at all-ones.
  - retire_count increments when pc_valid=1.
- Halt detection (RUN only):
  - When pc_valid=1 and pc==last_pc, the repeat counter increments. When pc_valid=1 and pc!=last_pc, it resets to 1.
  - When pc_valid=1, last_pc takes pc.
  - Cycles with pc_valid=0 leave last_pc and the repeat counter unchanged.
  - The halt condition is met when the retiring instruction makes HALT_REPEAT consecutive identical PCs.
- End conditions, evaluated in RUN each cycle with fixed priority:
  1. Signature: mem_wen=1 and mem_addr==SIG_ADDR. pass = (mem_wdata==PASS_VAL), fail = its complement.
  2. Halt: set halt.
  3. Timeout: cycle_count==MAX_CYCLES-1 in this cycle. Set timeout.
  - On any end event, go to DONE on the same edge and set done. Only the highest-priority flag is set.
  - Counters include the terminating cycle.
- DONE: core_rst_n=0, which freezes the core. Flags and counters hold. start=1 restarts through RST_HOLD and clears everything.
- start is ignored in RST_HOLD and RUN.
- Exactly one of pass, fail, halt, timeout is 1 whenever done=1. All four are 0 when done=0.

Decomposition:
- Shared package mips_sim_pkg holds the run_state encoding (IDLE, RST_HOLD, RUN, DONE), default SIG_ADDR and PASS_VAL, and the width constants.
- One natural sub-module: mips_halt_detect. It contains last_pc, the repeat counter and the halt condition, with a clear input driven by the start/restart edge.

Test Plan:
- Hold after start: mips_cpu_reset low for 3 cycles then high, start pulse. Required: core_rst_n low for exactly 4 cycles after start, state sequence IDLE→RST_HOLD→RUN, cycle_count=0 on the first RUN cycle.
- Signature pass: in RUN, mem_wen=1, mem_addr=0xC00, mem_wdata=1 at run cycle 50, with pc_valid every cycle. Required: done=1, pass=1, cycle_count=51, retire_count=51, core_rst_n=0. Repeat with mem_wdata=0xDEAD. Required: fail=1, pass=0.
- Halt: retire the PC sequence 0x0,0x4,0x8 then 0x8 repeated, with HALT_REPEAT=8. Required: halt=1 on the edge of the 8th consecutive 0x8 retirement. A pc_valid=0 gap in the middle does not reset the count.
- Timeout: MAX_CYCLES=100 with no stores and incrementing PCs. Required: timeout=1, done=1, cycle_count=100.
- Simultaneous: signature store and 8th repeated PC in the same cycle. Required: pass=1, halt=0. Async reset asserted mid-RUN. Required: immediate IDLE, core_rst_n=0, all flags and counters 0.
- Restart: start pulse in DONE. Required: flags clear, re-enter RST_HOLD, second run counts from 0. A start pulse during RUN has no effect.
